// File: rtl/simon_pkg.sv
// Shared SIMON32/64 constants, FSM state type and round-function helpers
// used by the encrypt core, decrypt core and key expansion.
package simon_pkg;

  localparam int N = 16;
  localparam int M = 4;
  // SIMON32/64 (four key words) runs 32 rounds.
  localparam int T = (M == 4) ? 32 : 0;
  localparam int C = 5;

  localparam logic [C:0] CNT_INIT = (C+1)'(T-1);
  localparam logic [C:0] CNT_ONE  = (C+1)'(1);

  typedef enum logic [1:0] {IDLE, WAIT_KEY, RUN, DONE} state_e;

  function automatic logic [N-1:0] rotl(input logic [N-1:0] v, input int unsigned s);
    logic [2*N-1:0] dbl;
    dbl = {v, v} << (s % N);
    return dbl[2*N-1:N];
  endfunction

  function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

endpackage

// File: rtl/simon_round_inv.sv
// One inverse SIMON Feistel round, purely combinational.
module simon_round_inv
  import simon_pkg::*;
(
  input  logic [N-1:0] x_i,
  input  logic [N-1:0] y_i,
  input  logic [N-1:0] rkey_i,
  output logic [N-1:0] x_o,
  output logic [N-1:0] y_o
);

  assign x_o = y_i;
  assign y_o = x_i ^ simon_f(y_i) ^ rkey_i;

endmodule

// File: rtl/simon_decrypt_core.sv
// Iterative SIMON32/64 decryption: one inverse round per clock, walking the
// round-key schedule from T-1 down to 0.
module simon_decrypt_core
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                R,
  input  logic                start,
  input  logic [1:0][N-1:0]   ct,
  input  logic                doneKey,
  input  logic [N-1:0]        rKey,
  output logic [C:0]          count,
  output logic                busy,
  output logic                done,
  output logic [1:0][N-1:0]   pt
);

  state_e           state_q, state_d;
  logic [C:0]       count_q, count_d;
  logic [N-1:0]     x_q, x_d, y_q, y_d;
  logic [N-1:0]     x_rnd, y_rnd;
  logic [1:0][N-1:0] ct_q, ct_d, pt_q, pt_d;

  simon_round_inv u_round (
    .x_i    (x_q),
    .y_i    (y_q),
    .rkey_i (rKey),
    .x_o    (x_rnd),
    .y_o    (y_rnd)
  );

  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state_q <= IDLE;
      count_q <= CNT_INIT;
      x_q     <= '0;
      y_q     <= '0;
      ct_q    <= '0;
      pt_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ct_q    <= ct_d;
      pt_q    <= pt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    x_d     = x_q;
    y_d     = y_q;
    ct_d    = ct_q;
    pt_d    = pt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ct_d    = ct;
          x_d     = ct[1];
          y_d     = ct[0];
          count_d = CNT_INIT;
          state_d = doneKey ? RUN : WAIT_KEY;
        end
      end
      WAIT_KEY: begin
        if (doneKey) state_d = RUN;
      end
      RUN: begin
        // Schedule went away mid-block: restart from the saved ciphertext.
        if (!doneKey) begin
          x_d     = ct_q[1];
          y_d     = ct_q[0];
          count_d = CNT_INIT;
          state_d = WAIT_KEY;
        end else begin
          x_d = x_rnd;
          y_d = y_rnd;
          if (count_q == '0) begin
            pt_d    = {x_rnd, y_rnd};
            count_d = CNT_INIT;
            state_d = DONE;
          end else begin
            count_d = count_q - CNT_ONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == WAIT_KEY) || (state_q == RUN);
  assign done  = (state_q == DONE);
  assign pt    = pt_q;

endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed + randomized bench for simon_decrypt_core against a plain SIMON32/64 model.
module tb_simon_decrypt_core;

  localparam int W  = 16;
  localparam int TR = 32;
  localparam logic [31:0] KAT_CT  = 32'hc69b_e9bb;
  localparam logic [31:0] KAT_PT  = 32'h6565_6877;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;

  logic              clk = 1'b0;
  logic              R = 1'b1;
  logic              start = 1'b0;
  logic              doneKey = 1'b0;
  logic [1:0][W-1:0] ct = '0;
  logic [W-1:0]      rKey;
  logic [5:0]        count;
  logic              busy, done;
  logic [1:0][W-1:0] pt;
  logic [W-1:0]      rk [0:63];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign rKey = rk[count];

  simon_decrypt_core dut (
    .clk(clk), .R(R), .start(start), .ct(ct), .doneKey(doneKey), .rKey(rKey),
    .count(count), .busy(busy), .done(done), .pt(pt)
  );

  function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int s);
    return (v << s) | (v >> (W - s));
  endfunction

  function automatic logic [W-1:0] fr(input logic [W-1:0] v);
    return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
  endfunction

  // Standard SIMON32/64 key schedule (z0 sequence, c = 2^16-4).
  task automatic expand(input logic [63:0] key);
    logic [W-1:0] tmp;
    logic [61:0]  z;
    z = {2{31'b1111101000100101011000011100110}};
    rk[0] = key[15:0];
    rk[1] = key[31:16];
    rk[2] = key[47:32];
    rk[3] = key[63:48];
    for (int i = 4; i < TR; i++) begin
      tmp   = rol(rk[i-1], W - 3) ^ rk[i-3];
      tmp   = tmp ^ rol(tmp, W - 1);
      rk[i] = ~rk[i-4] ^ tmp ^ {15'd0, z[61 - ((i - 4) % 62)]} ^ 16'd3;
    end
  endtask

  function automatic logic [31:0] enc(input logic [31:0] p);
    logic [W-1:0] x, y, t;
    x = p[31:16];
    y = p[15:0];
    for (int i = 0; i < TR; i++) begin
      t = x;
      x = y ^ fr(x) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic launch(input logic [31:0] c);
    @(negedge clk);
    ct    = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, n2, errs;
    logic [31:0] p, c;
    for (int i = 0; i < 64; i++) rk[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'(TR - 1));
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pt",    32'(pt), 32'd0);
    R = 1'b0;

    // Known answer with the schedule ready, count walking 31..0.
    expand(KAT_KEY);
    doneKey = 1'b1;
    launch(KAT_CT);
    errs = 0;
    for (int k = 0; k < TR; k++) begin
      if (count !== 6'(TR - 1 - k) || done !== 1'b0 || busy !== 1'b1) errs++;
      @(negedge clk);
    end
    chk("kat_seq",  32'(errs), 32'd0);
    chk("kat_done", 32'(done), 32'd1);
    chk("kat_pt",   32'(pt), KAT_PT);
    @(negedge clk);
    chk("kat_pulse", 32'(done), 32'd0);
    chk("kat_idle",  32'(busy), 32'd0);
    chk("kat_cnt",   32'(count), 32'(TR - 1));

    // Key not ready: hold in WAIT_KEY, then T+1 edges after doneKey rises.
    doneKey = 1'b0;
    launch(KAT_CT);
    errs = 0;
    repeat (10) begin
      if (busy !== 1'b1 || count !== 6'(TR - 1) || done !== 1'b0) errs++;
      @(negedge clk);
    end
    chk("nokey_hold", 32'(errs), 32'd0);
    doneKey = 1'b1;
    wait_done(100, n);
    chk("nokey_lat", 32'(n), 32'(TR + 1));
    chk("nokey_pt",  32'(pt), KAT_PT);
    @(negedge clk);

    // Leave a distinct plaintext behind so the abort can show pt is held.
    p = $urandom;
    c = enc(p);
    launch(c);
    wait_done(100, n);
    chk("prev_pt", 32'(pt), p);
    @(negedge clk);

    // Abort after 12 rounds, schedule regenerated, restart from 31.
    launch(KAT_CT);
    repeat (12) @(negedge clk);
    chk("abort_pre_cnt", 32'(count), 32'(TR - 1 - 12));
    doneKey = 1'b0;
    for (int i = 0; i < TR; i++) rk[i] = '0;
    @(negedge clk);
    chk("abort_cnt",  32'(count), 32'(TR - 1));
    chk("abort_busy", 32'(busy), 32'd1);
    errs = 0;
    repeat (5) begin
      if (done !== 1'b0 || pt !== p) errs++;
      @(negedge clk);
    end
    chk("abort_hold", 32'(errs), 32'd0);
    expand(KAT_KEY);
    doneKey = 1'b1;
    wait_done(100, n);
    chk("abort_lat", 32'(n), 32'(TR + 1));
    chk("abort_pt",  32'(pt), KAT_PT);
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) errs++;
    end
    chk("abort_single", 32'(errs), 32'd0);

    // Start during RUN and during DONE is ignored.
    launch(KAT_CT);
    repeat (5) @(negedge clk);
    ct    = ~KAT_CT;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(100, n);
    chk("ign_pt", 32'(pt), KAT_PT);
    ct    = 32'h1234_5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_done_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ign_done_idle", 32'(busy), 32'd0);

    // Start held high: blocks complete every T+2 clocks.
    ct    = KAT_CT;
    start = 1'b1;
    wait_done(100, n);
    chk("b2b_pt1", 32'(pt), KAT_PT);
    @(negedge clk);
    wait_done(100, n2);
    start = 1'b0;
    chk("b2b_gap", 32'(n2 + 1), 32'(TR + 2));
    chk("b2b_pt2", 32'(pt), KAT_PT);
    repeat (2) @(negedge clk);
    chk("b2b_stop", 32'(busy), 32'd0);

    // Round trip under a random key.
    expand({$urandom, $urandom});
    for (int b = 0; b < 100; b++) begin
      p = $urandom;
      c = enc(p);
      launch(c);
      wait_done(100, n);
      chk("rt_pt", 32'(pt), p);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a run.
    launch(c);
    repeat (5) @(negedge clk);
    #2 R = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'(TR - 1));
    chk("arst_busy",  32'(busy), 32'd0);
    chk("arst_done",  32'(done), 32'd0);
    chk("arst_pt",    32'(pt), 32'd0);
    @(negedge clk);
    R = 1'b0;
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) errs++;
    end
    chk("arst_quiet", 32'(errs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
